debug_reader: RTL and testbench
===============================

DEBUG_READER -- requirements
Module: debug_reader

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2: cycles each select value is held before sampling; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1: request one snapshot; sampled only in IDLE.
REQ-005 The block SHALL have port reg_out_select, output, 4: nibble select driven to the core debug port.
REQ-006 The block SHALL have port reg_out_out, input, 4: selected nibble returned by the core.
REQ-007 The block SHALL have port pc_in, input, 32: core PC, captured at snapshot start.
REQ-008 The block SHALL have port busy, output, 1: high from start acceptance until the last frame byte is accepted.
REQ-009 The block SHALL have port dout_valid, output, 1: frame byte available.
REQ-010 The block SHALL have port dout_ready, input, 1: sink accepts the byte when valid and ready are both high at a rising edge.
REQ-011 The block SHALL have port dout_data, output, 8: current frame byte.

Function
REQ-012 FSM states SHALL be IDLE, SCAN, SEND.
REQ-013 IDLE with start=1 at a clock edge SHALL trigger these actions:
- capture pc_in into the PC latch;
- set select to 0;
- assert busy;
- enter SCAN.
REQ-014 In SCAN, each select value SHALL be held for exactly SETTLE_CYCLES cycles.
REQ-015 In SCAN, reg_out_out SHALL be sampled into nibble buffer entry [select] at the edge ending the last hold cycle, and select SHALL increment at that same edge.
REQ-016 After entry 15 is sampled, the block SHALL enter SEND with byte index 0; scan duration is 16*SETTLE_CYCLES cycles.
REQ-017 The frame SHALL be 14 bytes in this order:
- byte 0: 0xA5;
- bytes 1-4: PC latch, most significant byte first;
- bytes 5-12: byte 5+k = {nibble[2k+1], nibble[2k]} for k=0..7;
- byte 13: XOR of bytes 1-12.
REQ-018 dout_valid SHALL be high throughout SEND, and dout_data SHALL equal the indexed frame byte.
REQ-019 Data SHALL be held stable while valid=1 and ready=0.
REQ-020 The byte index SHALL increment only on a handshake; back-to-back handshakes SHALL deliver one byte per cycle.
REQ-021 The handshake on byte 13 SHALL deassert busy and dout_valid on the next cycle and return to IDLE; a new start SHALL be accepted no earlier than the cycle after.
REQ-022 start while busy=1 SHALL be ignored (no queueing, no restart).
REQ-023 reg_out_select SHALL be 0 in IDLE and SEND.
REQ-024 The PC latch and the nibble buffer SHALL NOT change outside IDLE->SCAN capture and SCAN sampling.

Reset
REQ-025 reset low SHALL immediately force the following, regardless of state, including mid-SCAN and mid-SEND:
- state IDLE;
- busy=0, dout_valid=0, dout_data=0x00;
- reg_out_select=0, byte index=0;
- nibble buffer and PC latch cleared to 0.
REQ-026 After reset deasserts, the first start SHALL produce a complete fresh frame; no partial frame SHALL be resumed.

Structure
REQ-027 A shared package debug_reader_pkg SHALL define:
- the state enumeration;
- HEADER_BYTE=8'hA5;
- FRAME_LEN=14;
- NIBBLE_COUNT=16.
REQ-028 Frame-byte selection and the valid/ready index counter SHALL live in one sub-module, debug_frame_tx, which takes the PC latch and nibble buffer as inputs.
REQ-029 The scan counter and settle counter SHALL remain in the top module.

Verification
REQ-030 Scenario 1: SETTLE_CYCLES=2, pc_in=0x00000010, core model returns nibble=select, ready tied 1 -> bytes in order:
- A5, 00, 00, 00, 10;
- 10, 32, 54, 76, 98, BA, DC, FE;
- checksum 0x10.
First valid occurs 32 cycles after start acceptance.
REQ-031 Scenario 2: same stimulus, ready toggled 1,0,0,1 repeatedly -> identical byte sequence, dout_data constant across stall cycles, exactly 14 handshakes.
REQ-032 Scenario 3: start pulsed again during SCAN and during SEND -> exactly one frame produced, busy low only after the byte-13 handshake.
REQ-033 Scenario 4: reset asserted at scan select=7, then released, then start -> outputs zero during reset, then a complete new 14-byte frame with correct checksum.
REQ-034 Scenario 5: SETTLE_CYCLES=1, core model output changes 1 cycle after the select change -> sampled nibbles reflect the value present at the sampling edge, matching the reference model.

Source files
------------

// File: rtl/debug_reader_pkg.sv
// Shared types, frame constants and frame-byte selection for the debug snapshot reader.
package debug_reader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      SEND
   } state_t;

   localparam logic [7:0] HEADER_BYTE  = 8'hA5;
   localparam int         FRAME_LEN    = 14;
   localparam int         NIBBLE_COUNT = 16;

   // nib holds nibble i at bits [4i+3:4i], so frame byte 5+k is simply nib[8k+7:8k].
   function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                             input logic [31:0] pc,
                                             input logic [63:0] nib);
      logic [7:0] b;
      b = '0;
      case (idx)
         4'd0:  b = HEADER_BYTE;
         4'd1:  b = pc[31:24];
         4'd2:  b = pc[23:16];
         4'd3:  b = pc[15:8];
         4'd4:  b = pc[7:0];
         4'd5:  b = nib[7:0];
         4'd6:  b = nib[15:8];
         4'd7:  b = nib[23:16];
         4'd8:  b = nib[31:24];
         4'd9:  b = nib[39:32];
         4'd10: b = nib[47:40];
         4'd11: b = nib[55:48];
         4'd12: b = nib[63:56];
         4'd13: begin
            b = pc[31:24] ^ pc[23:16] ^ pc[15:8] ^ pc[7:0];
            for (int unsigned k = 0; k < 8; k++) begin
               b = b ^ nib[8*k +: 8];
            end
         end
         default: b = '0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/debug_reader_frame_tx.sv
// Frame transmitter: walks the 14-byte frame over a valid/ready interface.
module debug_frame_tx
   import debug_reader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic [31:0] pc_i,
   input  logic [63:0] nib_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [7:0]  data_o,
   output logic        done_o
);

   logic       valid_q;
   logic [3:0] idx_q;
   logic [7:0] data_q;
   logic       hs;
   logic       last;

   assign hs   = valid_q & ready_i;
   assign last = (idx_q == 4'(FRAME_LEN - 1));

   // Data is registered one byte ahead of the index, so it only moves on a handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         idx_q   <= '0;
         data_q  <= HEADER_BYTE;
      end else if (hs) begin
         if (last) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
         end else begin
            idx_q   <= idx_q + 4'd1;
            data_q  <= frame_byte(idx_q + 4'd1, pc_i, nib_i);
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign done_o  = hs & last;

endmodule

// File: rtl/debug_reader.sv
// Debug snapshot reader: scans 16 core nibbles through a select port, then frames them with the PC.
module debug_reader
   import debug_reader_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [3:0]  reg_out_select,
   input  logic [3:0]  reg_out_out,
   input  logic [31:0] pc_in,
   output logic        busy,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic [7:0]  dout_data
);

   state_t                         state_q;
   logic [3:0]                     sel_q;
   logic [3:0]                     settle_q;
   logic [3:0]                     settle_d;
   logic [31:0]                    pc_q;
   logic [NIBBLE_COUNT-1:0][3:0]   nib_q;
   logic                           busy_q;
   logic                           settle_done;
   logic                           scan_done;
   logic                           tx_done;

   assign settle_done = (settle_q == 4'(SETTLE_CYCLES - 1));
   assign scan_done   = (state_q == SCAN) && settle_done && (sel_q == 4'(NIBBLE_COUNT - 1));

   always_comb begin
      settle_d = settle_q + 4'd1;
      if (settle_done) settle_d = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         settle_q <= '0;
         pc_q     <= '0;
         nib_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  pc_q     <= pc_in;
                  sel_q    <= '0;
                  settle_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= SCAN;
               end
            end
            SCAN: begin
               settle_q <= settle_d;
               if (settle_done) begin
                  nib_q[sel_q] <= reg_out_out;
                  if (sel_q == 4'(NIBBLE_COUNT - 1)) begin
                     sel_q   <= '0;
                     state_q <= SEND;
                  end else begin
                     sel_q   <= sel_q + 4'd1;
                  end
               end
            end
            SEND: begin
               if (tx_done) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   debug_frame_tx u_tx (
      .clk     (clk),
      .reset   (reset),
      .load_i  (scan_done),
      .pc_i    (pc_q),
      .nib_i   (nib_q),
      .ready_i (dout_ready),
      .valid_o (dout_valid),
      .data_o  (dout_data),
      .done_o  (tx_done)
   );

   assign reg_out_select = sel_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_debug_reader.sv
// Scoreboard bench: expected frame bytes are queued at start, monitors pop on each handshake.
module tb_debug_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start0, start1;
   logic        ready0, ready1;
   logic [3:0]  sel0, sel1, rout0, rout1;
   logic [31:0] pc0, pc1;
   logic        busy0, busy1, valid0, valid1;
   logic [7:0]  data0, data1;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  q0[$];
   logic [7:0]  q1[$];
   int          hs0 = 0;
   int          hs1 = 0;
   int          rmode = 0;

   always #5 clk = ~clk;

   debug_reader #(.SETTLE_CYCLES(2)) dut0 (
      .clk(clk), .reset(rst_n), .start(start0), .reg_out_select(sel0), .reg_out_out(rout0),
      .pc_in(pc0), .busy(busy0), .dout_valid(valid0), .dout_ready(ready0), .dout_data(data0));

   debug_reader #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .reset(rst_n), .start(start1), .reg_out_select(sel1), .reg_out_out(rout1),
      .pc_in(pc1), .busy(busy1), .dout_valid(valid1), .dout_ready(ready1), .dout_data(data1));

   // Core models: dut0 answers combinationally with the select; dut1 answers ~select one cycle late.
   assign rout0 = sel0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rout1 <= 4'h0;
      else        rout1 <= ~sel1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int which, input logic [111:0] f);
      for (int i = 0; i < 14; i++) begin
         if (which == 0) q0.push_back(f[8*(13-i) +: 8]);
         else            q1.push_back(f[8*(13-i) +: 8]);
      end
   endtask

   task automatic pulse_start(input int which);
      @(negedge clk);
      if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_done(input int which, input string name);
      int cyc;
      cyc = 0;
      while (cyc < 400 && ((which == 0) ? (busy0 || q0.size() != 0) : (busy1 || q1.size() != 0))) begin
         @(negedge clk);
         cyc++;
      end
      chk({name, "_timeout"}, (cyc < 400) ? 32'd1 : 32'd0, 32'd1);
      chk({name, "_queue_empty"}, (which == 0) ? q0.size() : q1.size(), 32'd0);
      chk({name, "_handshakes"}, (which == 0) ? hs0 : hs1, 32'd14);
   endtask

   task automatic latency(input int which, input int exp, input string name);
      int cyc;
      cyc = 0;
      while (cyc < 100 && !((which == 0) ? valid0 : valid1)) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk(name, cyc, exp);
   endtask

   // Ready driver: tied high, or repeating 1,0,0,1.
   initial begin
      logic [3:0] pat;
      int         ph;
      pat = 4'b1001;
      ph  = 0;
      ready0 = 1'b1;
      ready1 = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (rmode == 0) ready0 = 1'b1;
         else begin
            ready0 = pat[ph];
            ph = (ph + 1) % 4;
         end
      end
   end

   initial begin
      logic       stall;
      logic [7:0] held;
      stall = 1'b0;
      held  = '0;
      forever begin
         @(negedge clk);
         if (rst_n && valid0) begin
            if (stall) chk("stall_hold", data0, held);
            chk("busy_in_send", busy0, 1'b1);
            chk("sel_in_send", 32'(sel0), 32'd0);
            if (ready0) begin
               hs0++;
               stall = 1'b0;
               if (q0.size() == 0) chk("unexpected_byte0", data0, 32'hFFFF);
               else                chk("frame0_byte", data0, q0.pop_front());
            end else begin
               stall = 1'b1;
               held  = data0;
            end
         end else begin
            stall = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && valid1 && ready1) begin
            hs1++;
            if (q1.size() == 0) chk("unexpected_byte1", data1, 32'hFFFF);
            else                chk("frame1_byte", data1, q1.pop_front());
         end
      end
   end

   initial begin
      logic [111:0] f1, f4, f5;
      int           cyc;
      int           stray;
      f1 = 112'hA5_00000010_1032547698BADCFE_10;
      f4 = 112'hA5_DEADBEEF_1032547698BADCFE_22;
      f5 = 112'hA5_12345678_FFDEBC9A78563412_07;

      rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
      pc0 = '0; pc1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy0", busy0, 1'b0);
      chk("rst_valid0", valid0, 1'b0);
      chk("rst_data0", data0, 8'h00);
      chk("rst_sel0", 32'(sel0), 32'd0);
      chk("rst_busy1", busy1, 1'b0);
      chk("rst_valid1", valid1, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Scenario 1: ready tied high
      pc0 = 32'h0000_0010;
      hs0 = 0;
      push_frame(0, f1);
      pulse_start(0);
      latency(0, 32, "s1_first_valid_latency");
      wait_done(0, "s1");
      repeat (3) @(negedge clk);
      chk("s1_idle_valid", valid0, 1'b0);
      chk("s1_idle_busy", busy0, 1'b0);

      // Scenario 2: ready 1,0,0,1
      rmode = 1;
      hs0 = 0;
      push_frame(0, f1);
      pulse_start(0);
      wait_done(0, "s2");

      // Scenario 3: extra start pulses in SCAN and SEND with a different PC present
      hs0 = 0;
      push_frame(0, f1);
      pulse_start(0);
      repeat (10) @(negedge clk);
      pc0 = 32'hFFFF_FFFF;
      pulse_start(0);
      cyc = 0;
      while (!valid0 && cyc < 100) begin @(negedge clk); cyc++; end
      chk("s3_reach_send", valid0, 1'b1);
      repeat (3) @(negedge clk);
      pulse_start(0);
      wait_done(0, "s3");
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (valid0 || busy0) stray++;
      end
      chk("s3_no_second_frame", stray, 0);
      rmode = 0;

      // Scenario 4: reset mid-scan at select 7
      pc0 = 32'hDEAD_BEEF;
      pulse_start(0);
      cyc = 0;
      while (sel0 != 4'd7 && cyc < 100) begin @(negedge clk); cyc++; end
      chk("s4_reach_sel7", 32'(sel0), 32'd7);
      rst_n = 1'b0;
      #1;
      chk("s4_rst_busy", busy0, 1'b0);
      chk("s4_rst_valid", valid0, 1'b0);
      chk("s4_rst_data", data0, 8'h00);
      chk("s4_rst_sel", 32'(sel0), 32'd0);
      repeat (2) @(negedge clk);
      chk("s4_rst_hold_busy", busy0, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("s4_post_rst_idle", valid0, 1'b0);
      hs0 = 0;
      push_frame(0, f4);
      pulse_start(0);
      wait_done(0, "s4");

      // Scenario 5: SETTLE_CYCLES=1 with a core answering one cycle late
      pc1 = 32'h1234_5678;
      hs1 = 0;
      push_frame(1, f5);
      pulse_start(1);
      latency(1, 16, "s5_first_valid_latency");
      wait_done(1, "s5");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
